// File: rtl/gf2m_reduce_seq.sv
// Sequential GF(2^M) reducer mod x^M + x^K + 1, folding CHUNK bits per clock.
// Optional GF2M_RED_STATS_EN adds a saturating red_count of output handshakes.
module gf2m_reduce_seq #(
  parameter int M     = 409,
  parameter int K     = 87,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*M-2:0]   prod_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     res_out,
  output logic             busy
`ifdef GF2M_RED_STATS_EN
  ,
  output logic [15:0]      red_count
`endif
);

  localparam int W  = 2*M-1;
  localparam int PW = $clog2(W+1);
  localparam logic [PW-1:0] MP = PW'(M);
  localparam logic [PW-1:0] CP = PW'(CHUNK);
  localparam logic [PW-1:0] WP = PW'(W);

  if (K < 1 || K >= M || CHUNK < 1 || CHUNK > M-K) begin : g_bad_cfg
    $error("gf2m_reduce_seq: illegal M/K/CHUNK combination");
  end

  typedef enum logic [1:0] {IDLE, FOLD, DONE} state_t;

  state_t        state, state_next;
  logic [W-1:0]  w, w_next, hmask, h;
  logic [PW-1:0] ptr, ptr_next, rem, n;

  // Bits at or above ptr are already zero, so the window is everything above ptr-n.
  always_comb begin
    rem      = ptr - MP;
    n        = (rem > CP) ? CP : rem;
    ptr_next = ptr - n;
    hmask    = '0;
    for (int i = 0; i < W; i++) begin
      hmask[i] = (i >= int'(ptr_next));
    end
    h      = w & hmask;
    w_next = (w & ~hmask) ^ (h >> M) ^ (h >> (M-K));
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = FOLD;
      end
      FOLD: begin
        busy = 1'b1;
        if (ptr_next == MP) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      w       <= '0;
      ptr     <= MP;
      res_out <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && in_valid) begin
        w   <= prod_in;
        ptr <= WP;
      end else if (state == FOLD) begin
        w   <= w_next;
        ptr <= ptr_next;
        if (ptr_next == MP) res_out <= w_next[M-1:0];
      end
    end
  end

`ifdef GF2M_RED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      red_count <= '0;
    end else if (out_valid && out_ready && red_count != 16'hFFFF) begin
      red_count <= red_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gf2m_reduce_seq.sv
// Directed self-checking bench for gf2m_reduce_seq (M=409, K=87, CHUNK=64).
// Expected residues are hand-derived or from a bit-serial fold model.
module tb_gf2m_reduce_seq;

  localparam int M = 409;
  localparam int K = 87;
  localparam int W = 2*M-1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] prod_in;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] res_out;
  logic         busy;
`ifdef GF2M_RED_STATS_EN
  logic [15:0]  red_count;
`endif

  int tests = 0;
  int fails = 0;

  gf2m_reduce_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod_in   (prod_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_out   (res_out),
    .busy      (busy)
`ifdef GF2M_RED_STATS_EN
    ,
    .red_count (red_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [M-1:0] ref_red(input logic [W-1:0] p);
    logic [W-1:0] t;
    t = p;
    for (int i = W-1; i >= M; i--) begin
      if (t[i]) begin
        t[i]       = 1'b0;
        t[i-M]     = t[i-M] ^ 1'b1;
        t[i-M+K]   = t[i-M+K] ^ 1'b1;
      end
    end
    return t[M-1:0];
  endfunction

  task automatic chk(input string tag, input logic [M-1:0] obs,
                     input logic [M-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 30) begin
      step();
      cyc++;
    end
  endtask

  task automatic job(input logic [W-1:0] p, input logic [M-1:0] exp,
                     input string tag);
    int cyc;
    in_valid = 1'b1;
    prod_in  = p;
    step();
    in_valid = 1'b0;
    prod_in  = '0;
    chk({tag, "_rdy_low"}, M'(in_ready), M'(0));
    chk({tag, "_busy"}, M'(busy), M'(1));
    wait_out(cyc);
    chk({tag, "_lat"}, M'(cyc), M'(7));
    chk({tag, "_res"}, res_out, exp);
    chk({tag, "_rdy_done"}, M'(in_ready), M'(0));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, M'(out_valid), M'(0));
    chk({tag, "_rdy_idle"}, M'(in_ready), M'(1));
  endtask

  initial begin
    logic [W-1:0] p;
    logic [M-1:0] e;
    logic [M-1:0] held;
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    prod_in   = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", M'(in_ready), M'(1));
    chk("rst_out_valid", M'(out_valid), M'(0));
    chk("rst_busy", M'(busy), M'(0));
    chk("rst_res", res_out, '0);
`ifdef GF2M_RED_STATS_EN
    chk("rst_cnt", M'(red_count), M'(0));
`endif

    p = '0; p[0] = 1'b1;
    e = '0; e[0] = 1'b1;
    job(p, e, "identity");

    p = '0; p[409] = 1'b1;
    e = '0; e[87] = 1'b1; e[0] = 1'b1;
    job(p, e, "single");

    p = '0; p[816] = 1'b1;
    e = '0; e[407] = 1'b1; e[172] = 1'b1; e[85] = 1'b1;
    job(p, e, "double");

    job('0, '0, "zero");

    p = '1;
    job(p, ref_red(p), "ones");

    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < W; j += 32) begin
        logic [31:0] r;
        r = $urandom;
        for (int b = 0; b < 32; b++) begin
          if (j + b < W) p[j+b] = r[b];
        end
      end
      job(p, ref_red(p), $sformatf("rand%0d", v));
    end

    // backpressure: hold DONE, with in_valid asserted and ignored
    p = '0; p[409] = 1'b1;
    e = '0; e[87] = 1'b1; e[0] = 1'b1;
    in_valid = 1'b1;
    prod_in  = p;
    step();
    in_valid = 1'b0;
    wait_out(cyc);
    chk("bp_lat", M'(cyc), M'(7));
    held = res_out;
    chk("bp_res", held, e);
    in_valid = 1'b1;
    prod_in  = '1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_ov", M'(out_valid), M'(1));
      chk("bp_hold", res_out, e);
      chk("bp_rdy", M'(in_ready), M'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_ov_drop", M'(out_valid), M'(0));
    chk("bp_idle", M'(in_ready), M'(1));

    // reset during third fold cycle
    p = '1;
    in_valid = 1'b1;
    prod_in  = p;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_ov", M'(out_valid), M'(0));
    chk("mid_rst_busy", M'(busy), M'(0));
    chk("mid_rst_rdy", M'(in_ready), M'(1));
`ifdef GF2M_RED_STATS_EN
    chk("mid_rst_cnt", M'(red_count), M'(0));
`endif
    p = '0; p[816] = 1'b1;
    e = '0; e[407] = 1'b1; e[172] = 1'b1; e[85] = 1'b1;
    job(p, e, "after_rst");
`ifdef GF2M_RED_STATS_EN
    chk("cnt_after", M'(red_count), M'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
